vb_mode_ctrl: RTL



---
 rtl/vb_pkg.sv | 26 ++
 rtl/vb_mode_ctrl_if.sv | 36 +++
 rtl/vb_frame_meter.sv | 148 ++++++++++++++
 rtl/vb_mode_ctrl.sv | 111 +++++++++++
 4 files changed

// File: rtl/vb_pkg.sv
// vb_pkg: shared definitions for the vb mode controller.
//   - lock FSM state encoding (NOVID / MEASURE / LOCKED)
//   - default mode-bus width, mode count and reset mode
//   - vb_next_mode(): successor of a mode in the auto-cycle ring
package vb_pkg;

  localparam int VB_MODE_W       = 2;
  localparam int VB_NUM_MODES    = 4;
  localparam int VB_DEFAULT_MODE = 3;

  typedef enum logic [1:0] {
    ST_NOVID   = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } vb_state_e;

  // Next mode in the auto-cycle ring; any out-of-range value wraps to 0.
  function automatic int vb_next_mode(input int cur, input int num);
    if (cur >= num - 1) begin
      return 0;
    end else begin
      return cur + 1;
    end
  endfunction

endpackage

// File: rtl/vb_mode_ctrl_if.sv
// vb_mode_ctrl_if: timing inputs, mode request inputs and status outputs of
// vb_mode_ctrl.
//   master (video source / host side): drives rx_*, sel_mode, sel_valid,
//     auto_en; observes mode_out, mode_changed, locked, active_w, active_h.
//   slave (vb_mode_ctrl): the reverse.
interface vb_mode_ctrl_if
  import vb_pkg::*;
#(
  parameter int MODE_W = VB_MODE_W,
  parameter int H_W    = 12,
  parameter int V_W    = 12
);

  logic              rx_de;
  logic              rx_hsync;
  logic              rx_vsync;
  logic [MODE_W-1:0] sel_mode;
  logic              sel_valid;
  logic              auto_en;
  logic [MODE_W-1:0] mode_out;
  logic              mode_changed;
  logic              locked;
  logic [H_W-1:0]    active_w;
  logic [V_W-1:0]    active_h;

  modport master (
    output rx_de, rx_hsync, rx_vsync, sel_mode, sel_valid, auto_en,
    input  mode_out, mode_changed, locked, active_w, active_h
  );

  modport slave (
    input  rx_de, rx_hsync, rx_vsync, sel_mode, sel_valid, auto_en,
    output mode_out, mode_changed, locked, active_w, active_h
  );

endinterface

// File: rtl/vb_frame_meter.sv
// vb_frame_meter: measures the incoming active resolution and decides lock.
//   rx_pclk, rst_n : pixel clock, async active-low reset
//   rx_de_i        : data enable
//   rx_vsync_i     : vsync, active high
//   fs_o           : one-cycle frame start, registered rising edge of vsync
//   locked_o       : stable video detected
//   active_w_o/h_o : pixels per line / lines per frame of the last frame
module vb_frame_meter
  import vb_pkg::*;
#(
  parameter int H_W         = 12,
  parameter int V_W         = 12,
  parameter int LOCK_FRAMES = 3,
  parameter int NOVID_CYC   = 4194304
) (
  input  logic           rx_pclk,
  input  logic           rst_n,
  input  logic           rx_de_i,
  input  logic           rx_vsync_i,
  output logic           fs_o,
  output logic           locked_o,
  output logic [H_W-1:0] active_w_o,
  output logic [V_W-1:0] active_h_o
);

  localparam int WD_W = $clog2(NOVID_CYC + 1);
  localparam int LC_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(NOVID_CYC - 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LOCK_FRAMES - 1);

  logic            vs_q;
  logic            de_q;
  logic            fs_q;
  logic            run_done_q;
  logic [H_W-1:0]  pix_cnt_q;
  logic [V_W-1:0]  line_cnt_q;
  logic [H_W-1:0]  active_w_q;
  logic [V_W-1:0]  active_h_q;
  logic [WD_W-1:0] wd_cnt_q;
  logic [LC_W-1:0] lock_cnt_q;
  vb_state_e       state_q;
  logic            locked_q;

  logic de_rise_s;
  logic de_fall_s;
  logic equal_s;
  logic wd_fire_s;

  assign de_rise_s = rx_de_i & ~de_q;
  assign de_fall_s = ~rx_de_i & de_q;
  // A zero measurement never counts as a match, so an empty frame cannot lock.
  assign equal_s   = (pix_cnt_q == active_w_q) && (line_cnt_q == active_h_q) &&
                     (pix_cnt_q != {H_W{1'b0}}) && (line_cnt_q != {V_W{1'b0}});
  assign wd_fire_s = (wd_cnt_q == WD_LAST);

  // Edge detects, pixel/line counters and the no-video watchdog.
  always_ff @(posedge rx_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      fs_q       <= 1'b0;
      run_done_q <= 1'b0;
      pix_cnt_q  <= {H_W{1'b0}};
      line_cnt_q <= {V_W{1'b0}};
      wd_cnt_q   <= {WD_W{1'b0}};
    end else begin
      vs_q <= rx_vsync_i;
      de_q <= rx_de_i;
      fs_q <= rx_vsync_i & ~vs_q;
      if (fs_q) begin
        run_done_q <= 1'b0;
        pix_cnt_q  <= {H_W{1'b0}};
        line_cnt_q <= {V_W{1'b0}};
        wd_cnt_q   <= {WD_W{1'b0}};
      end else begin
        // Only the first DE run of the frame is measured for width.
        if (rx_de_i && !run_done_q && (pix_cnt_q != {H_W{1'b1}})) begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
        end
        if (de_fall_s) begin
          run_done_q <= 1'b1;
        end
        if (de_rise_s && (line_cnt_q != {V_W{1'b1}})) begin
          line_cnt_q <= line_cnt_q + 1'b1;
        end
        // Held at its last value so NOVID stays forced until the next fs.
        if (!wd_fire_s) begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
      end
    end
  end

  // Lock FSM with latched resolution; a frame start takes precedence over the watchdog.
  always_ff @(posedge rx_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_NOVID;
      lock_cnt_q <= {LC_W{1'b0}};
      locked_q   <= 1'b0;
      active_w_q <= {H_W{1'b0}};
      active_h_q <= {V_W{1'b0}};
    end else if (fs_q) begin
      active_w_q <= pix_cnt_q;
      active_h_q <= line_cnt_q;
      case (state_q)
        ST_NOVID: begin
          state_q    <= ST_MEASURE;
          lock_cnt_q <= {LC_W{1'b0}};
        end
        ST_MEASURE: begin
          if (equal_s && (lock_cnt_q == LC_LAST)) begin
            state_q    <= ST_LOCKED;
            locked_q   <= 1'b1;
            lock_cnt_q <= {LC_W{1'b0}};
          end else if (equal_s) begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_q <= {LC_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (!equal_s) begin
            state_q    <= ST_MEASURE;
            locked_q   <= 1'b0;
            lock_cnt_q <= {LC_W{1'b0}};
          end
        end
        default: begin
          state_q    <= ST_NOVID;
          locked_q   <= 1'b0;
          lock_cnt_q <= {LC_W{1'b0}};
        end
      endcase
    end else if (wd_fire_s) begin
      state_q    <= ST_NOVID;
      locked_q   <= 1'b0;
      lock_cnt_q <= {LC_W{1'b0}};
      active_w_q <= {H_W{1'b0}};
      active_h_q <= {V_W{1'b0}};
    end
  end

  assign fs_o       = fs_q;
  assign locked_o   = locked_q;
  assign active_w_o = active_w_q;
  assign active_h_o = active_h_q;

endmodule

// File: rtl/vb_mode_ctrl.sv
// vb_mode_ctrl: frame-synchronous mode controller for the vb vision block.
//   rx_pclk, rst_n : pixel clock, async active-low reset
//   bus (slave)    : rx_de/rx_hsync/rx_vsync timing, sel_mode/sel_valid
//                    manual request, auto_en; mode_out, mode_changed,
//                    locked, active_w, active_h status.
// Manual and auto-cycle requests are parked in pend_mode_q and copied to
// mode_out only on a frame start, so vb never changes mode mid-frame.
module vb_mode_ctrl
  import vb_pkg::*;
#(
  parameter int MODE_W       = VB_MODE_W,
  parameter int NUM_MODES    = VB_NUM_MODES,
  parameter int DEFAULT_MODE = VB_DEFAULT_MODE,
  parameter int DWELL_FRAMES = 60,
  parameter int LOCK_FRAMES  = 3,
  parameter int H_W          = 12,
  parameter int V_W          = 12,
  parameter int NOVID_CYC    = 4194304
) (
  input  logic          rx_pclk,
  input  logic          rst_n,
  vb_mode_ctrl_if.slave bus
);

  localparam int DW_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [DW_W-1:0]   DW_LAST     = DW_W'(DWELL_FRAMES - 1);
  localparam logic [MODE_W:0]   NUM_MODES_L = (MODE_W + 1)'(NUM_MODES);
  localparam logic [MODE_W-1:0] DEF_MODE_L  = MODE_W'(DEFAULT_MODE);

  logic              fs_s;
  logic              locked_s;
  logic              sel_ok_s;
  logic              auto_roll_s;
  logic [MODE_W-1:0] next_mode_s;
  logic              unused_hsync_s;

  logic [MODE_W-1:0] pend_mode_q;
  logic              pend_q;
  logic [DW_W-1:0]   dwell_q;
  logic [MODE_W-1:0] mode_out_q;
  logic              mode_changed_q;

  vb_frame_meter #(
    .H_W         (H_W),
    .V_W         (V_W),
    .LOCK_FRAMES (LOCK_FRAMES),
    .NOVID_CYC   (NOVID_CYC)
  ) u_meter (
    .rx_pclk    (rx_pclk),
    .rst_n      (rst_n),
    .rx_de_i    (bus.rx_de),
    .rx_vsync_i (bus.rx_vsync),
    .fs_o       (fs_s),
    .locked_o   (locked_s),
    .active_w_o (bus.active_w),
    .active_h_o (bus.active_h)
  );

  // hsync carries no information the meter needs; DE edges delimit lines.
  assign unused_hsync_s = bus.rx_hsync;

  assign sel_ok_s    = bus.sel_valid && ({1'b0, bus.sel_mode} < NUM_MODES_L);
  assign auto_roll_s = fs_s && bus.auto_en && locked_s && (dwell_q == DW_LAST);
  assign next_mode_s = MODE_W'(vb_next_mode(int'(mode_out_q), NUM_MODES));

  // Pending request and dwell counter; a valid manual request beats an auto roll.
  always_ff @(posedge rx_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mode_q <= {MODE_W{1'b0}};
      pend_q      <= 1'b0;
      dwell_q     <= {DW_W{1'b0}};
    end else if (sel_ok_s) begin
      // Also on an fs cycle: the old pend_mode is applied, this one waits a frame.
      pend_mode_q <= bus.sel_mode;
      pend_q      <= 1'b1;
      dwell_q     <= {DW_W{1'b0}};
    end else if (auto_roll_s) begin
      pend_mode_q <= next_mode_s;
      pend_q      <= 1'b1;
      dwell_q     <= {DW_W{1'b0}};
    end else begin
      if (fs_s) begin
        pend_q <= 1'b0;
      end
      if (!bus.auto_en) begin
        dwell_q <= {DW_W{1'b0}};
      end else if (fs_s && locked_s) begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  // Apply the pending mode at a frame start. NOVID has no frame starts, so a
  // pending mode waits there and lands on the fs that brings video back.
  always_ff @(posedge rx_pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_out_q     <= DEF_MODE_L;
      mode_changed_q <= 1'b0;
    end else if (fs_s && pend_q) begin
      mode_out_q     <= pend_mode_q;
      mode_changed_q <= (pend_mode_q != mode_out_q);
    end else begin
      mode_changed_q <= 1'b0;
    end
  end

  assign bus.mode_out     = mode_out_q;
  assign bus.mode_changed = mode_changed_q;
  assign bus.locked       = locked_s;

endmodule
